iod_eye_flag_tracker: RTL and testbench
=======================================

# iod_eye_flag_tracker

Fabric-side training controller that sits directly downstream of a PolarFire RX IOD lane configured with its eye monitor enabled. It consumes the lane's `EYE_MONITOR_EARLY` and `EYE_MONITOR_LATE` flags and drives `EYE_MONITOR_CLEAR_FLAGS` back to the lane. It steps the lane delay line through `DELAY_LINE_MOVE`, `DELAY_LINE_DIRECTION` and `DELAY_LINE_LOAD` until the sampling point sits inside the eye, then reports done or error.

## Interface
Parameters:
- `SAMPLE_WINDOW`, default 16: number of cycles over which flags are counted per iteration (≥ 1).
- `CLEAR_CYCLES`, default 2: number of cycles `EYE_MONITOR_CLEAR_FLAGS` is held high (≥ 1).
- `SETTLE_CYCLES`, default 4: number of post-clear cycles during which flags are ignored (≥ 0).
- `THRESH`, default 4: hit count at or above which a flag counts as "active".
- `MAX_TAP`, default 127: upper tap limit.
- `MAX_STEPS`, default 255: maximum number of moves before the controller aborts.

Ports (name, direction, width, meaning):
- `FAB_CLK` in 1: the only clock.
- `RX_SYNC_RST` in 1: synchronous, active-high reset.
- `TRAIN_START` in 1: single-cycle start request.
- `EYE_MONITOR_EARLY` in 1: early flag from the IOD.
- `EYE_MONITOR_LATE` in 1: late flag from the IOD.
- `DELAY_LINE_OUT_OF_RANGE` in 1: range error from the IOD.
- `EYE_MONITOR_CLEAR_FLAGS` out 1: clear request to the IOD.
- `DELAY_LINE_LOAD` out 1: single-cycle pulse that reloads the static delay.
- `DELAY_LINE_MOVE` out 1: single-cycle pulse that moves the delay by one tap.
- `DELAY_LINE_DIRECTION` out 1: step direction; 1 = add delay, 0 = remove delay.
- `TAP_POS` out 8: signed-free tap offset relative to the load point.
- `EARLY_CNT` out 8: early hit count from the last window.
- `LATE_CNT` out 8: late hit count from the last window.
- `TRAIN_BUSY` out 1: training in progress.
- `TRAIN_DONE` out 1: training finished successfully (sticky).
- `TRAIN_ERR` out 1: training aborted (sticky).

## Operation
- Both flag inputs pass through one register stage (`e_q`, `l_q`). All counting uses the registered values.
- State machine states: IDLE, LOAD, CLEAR, SETTLE, SAMPLE, DECIDE, STEP, DONE, ERR.
- **IDLE / DONE / ERR:** `TRAIN_START`=1 moves to LOAD and clears `TRAIN_DONE`, `TRAIN_ERR`, `TAP_POS` and the step counter. `TRAIN_START` is ignored in every other state.
- **LOAD:** `DELAY_LINE_LOAD`=1 for exactly this one cycle, then CLEAR.
- **CLEAR:** `EYE_MONITOR_CLEAR_FLAGS`=1 for `CLEAR_CYCLES` cycles. `EARLY_CNT` and `LATE_CNT` are zeroed on entry. Then SETTLE, or SAMPLE if `SETTLE_CYCLES`=0.
- **SETTLE:** wait `SETTLE_CYCLES` cycles, then SAMPLE.
- **SAMPLE:** for `SAMPLE_WINDOW` cycles, increment `EARLY_CNT` when `e_q`=1 and `LATE_CNT` when `l_q`=1. Both counters saturate at 255. Then DECIDE.
- **DECIDE** (1 cycle):
  - If `EARLY_CNT` < `THRESH` and `LATE_CNT` < `THRESH`: go to DONE.
  - Otherwise set `DELAY_LINE_DIRECTION` = (`EARLY_CNT` > `LATE_CNT`). A tie selects 0.
  - Go to ERR if any of the following holds:
    - direction=1 and `TAP_POS`=`MAX_TAP`;
    - direction=0 and `TAP_POS`=0;
    - the step counter equals `MAX_STEPS`.
  - Otherwise go to STEP.
- **STEP** (1 cycle): `DELAY_LINE_MOVE`=1. `TAP_POS` changes by ±1. Step counter increments. Then CLEAR.
- **`DELAY_LINE_OUT_OF_RANGE`=1** while `TRAIN_BUSY` causes the next state to be ERR, and this takes priority over all other transitions.
- **`TRAIN_BUSY`** is 1 in every state from LOAD through STEP.
- **`TRAIN_DONE` / `TRAIN_ERR`** are 1 in DONE and ERR respectively, and are held until the next `TRAIN_START` or reset.
- **`DELAY_LINE_DIRECTION`** holds its last value outside DECIDE and STEP.

## Timing
- Reset: every output is 0 and the state is IDLE, effective on the clock edge where `RX_SYNC_RST`=1.
- A reset during any state, including mid-SAMPLE or mid-pulse, aborts with no further pulse issued.
- The `TRAIN_START` edge at cycle 0 puts the FSM in LOAD; `DELAY_LINE_LOAD` is high in cycle 1.
- Iteration length is `CLEAR_CYCLES` + `SETTLE_CYCLES` + `SAMPLE_WINDOW` + 2 cycles (DECIDE and STEP).
- With default parameters:
  - first DECIDE occurs in cycle 24;
  - a zero-step DONE asserts in cycle 25;
  - each additional step adds 24 cycles.
- `DELAY_LINE_DIRECTION` is stable from the DECIDE cycle through the STEP cycle. `DELAY_LINE_MOVE` never coincides with a direction change.
- `DELAY_LINE_LOAD`, `DELAY_LINE_MOVE` and `EYE_MONITOR_CLEAR_FLAGS` are never high in the same cycle.
- The flag register stage gives 1 cycle of latency. A flag asserted in the last SETTLE cycle is counted in the first SAMPLE cycle.

## Test plan
- **Flags held at 0:** start → LOAD pulse in cycle 1, CLEAR high in cycles 2–3, `TRAIN_DONE`=1 in cycle 25, `TAP_POS`=0, no MOVE pulse.
- **`EYE_MONITOR_EARLY`=1 for the first 3 windows, then 0:** → 3 MOVE pulses with DIRECTION=1, `TAP_POS`=3, `TRAIN_DONE`=1, `EARLY_CNT`=0 at done.
- **`EYE_MONITOR_LATE`=1 constantly from start:** → DIRECTION=0 with `TAP_POS`=0 at DECIDE → ERR, no MOVE pulse, `TRAIN_ERR`=1, `TRAIN_BUSY`=0.
- **`DELAY_LINE_OUT_OF_RANGE` pulsed during the second SAMPLE:** → ERR next cycle, no further MOVE or CLEAR.
- **Early and late alternating per window with `MAX_STEPS`=5:** → exactly 5 MOVE pulses, then `TRAIN_ERR`=1.
- **`RX_SYNC_RST` mid-SAMPLE, and `TRAIN_START` while busy:**
  - the reset zeroes all outputs on the following cycle;
  - `TRAIN_START` asserted while busy changes nothing.

Source files
------------

// File: rtl/iod_eye_flag_tracker.sv
// Eye-monitor training controller for a PolarFire RX IOD lane: counts early/late
// flags per window and steps the delay line until both flags stay below threshold.
module iod_eye_flag_tracker #(
  parameter int SAMPLE_WINDOW = 16,
  parameter int CLEAR_CYCLES  = 2,
  parameter int SETTLE_CYCLES = 4,
  parameter int THRESH        = 4,
  parameter int MAX_TAP       = 127,
  parameter int MAX_STEPS     = 255
) (
  input  logic       FAB_CLK,
  input  logic       RX_SYNC_RST,
  input  logic       TRAIN_START,
  input  logic       EYE_MONITOR_EARLY,
  input  logic       EYE_MONITOR_LATE,
  input  logic       DELAY_LINE_OUT_OF_RANGE,
  output logic       EYE_MONITOR_CLEAR_FLAGS,
  output logic       DELAY_LINE_LOAD,
  output logic       DELAY_LINE_MOVE,
  output logic       DELAY_LINE_DIRECTION,
  output logic [7:0] TAP_POS,
  output logic [7:0] EARLY_CNT,
  output logic [7:0] LATE_CNT,
  output logic       TRAIN_BUSY,
  output logic       TRAIN_DONE,
  output logic       TRAIN_ERR
);

  typedef enum logic [3:0] {
    S_IDLE, S_LOAD, S_CLEAR, S_SETTLE, S_SAMPLE, S_DECIDE, S_STEP, S_DONE, S_ERR
  } state_t;

  state_t      state, state_nxt;
  logic        e_q, l_q;
  logic [15:0] timer;
  logic [15:0] steps;
  logic [7:0]  tap, early_cnt, late_cnt;
  logic        dir_q, dir_nxt;
  logic        busy, quiet, step_err, start_ok;

  function automatic logic [7:0] sat_inc(input logic [7:0] v, input logic hit);
    if (hit && v != 8'hFF) return v + 8'd1;
    return v;
  endfunction

  // flag register stage: all counting is done on these
  always_ff @(posedge FAB_CLK) begin
    e_q <= EYE_MONITOR_EARLY;
    l_q <= EYE_MONITOR_LATE;
  end

  always_comb begin
    busy     = (state == S_LOAD)   || (state == S_CLEAR) || (state == S_SETTLE) ||
               (state == S_SAMPLE) || (state == S_DECIDE) || (state == S_STEP);
    quiet    = (int'(early_cnt) < THRESH) && (int'(late_cnt) < THRESH);
    start_ok = TRAIN_START && ((state == S_IDLE) || (state == S_DONE) || (state == S_ERR));
    // direction is resolved combinationally so it is already valid in the DECIDE cycle
    dir_nxt  = dir_q;
    if (state == S_DECIDE && !quiet) dir_nxt = (early_cnt > late_cnt);
    step_err = (dir_nxt && tap == 8'(MAX_TAP)) || (!dir_nxt && tap == 8'd0) ||
               (steps == 16'(MAX_STEPS));
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE, S_ERR: if (TRAIN_START) state_nxt = S_LOAD;
      S_LOAD:   state_nxt = S_CLEAR;
      S_CLEAR:  if (timer == 16'(CLEAR_CYCLES - 1))
                  state_nxt = (SETTLE_CYCLES == 0) ? S_SAMPLE : S_SETTLE;
      S_SETTLE: if (timer == 16'(SETTLE_CYCLES - 1)) state_nxt = S_SAMPLE;
      S_SAMPLE: if (timer == 16'(SAMPLE_WINDOW - 1)) state_nxt = S_DECIDE;
      S_DECIDE: state_nxt = quiet ? S_DONE : (step_err ? S_ERR : S_STEP);
      S_STEP:   state_nxt = S_CLEAR;
      default:  state_nxt = S_IDLE;
    endcase
    if (busy && DELAY_LINE_OUT_OF_RANGE) state_nxt = S_ERR;
  end

  always_ff @(posedge FAB_CLK) begin
    if (RX_SYNC_RST) begin
      state     <= S_IDLE;
      timer     <= '0;
      steps     <= '0;
      tap       <= '0;
      early_cnt <= '0;
      late_cnt  <= '0;
      dir_q     <= 1'b0;
    end else begin
      state <= state_nxt;
      timer <= (state_nxt != state) ? 16'd0 : timer + 16'd1;
      dir_q <= dir_nxt;
      if (start_ok) begin
        tap   <= '0;
        steps <= '0;
      end else if (state == S_STEP) begin
        tap   <= dir_q ? tap + 8'd1 : tap - 8'd1;
        steps <= steps + 16'd1;
      end
      if (state_nxt == S_CLEAR && state != S_CLEAR) begin
        early_cnt <= '0;
        late_cnt  <= '0;
      end else if (state == S_SAMPLE) begin
        early_cnt <= sat_inc(early_cnt, e_q);
        late_cnt  <= sat_inc(late_cnt, l_q);
      end
    end
  end

  assign EYE_MONITOR_CLEAR_FLAGS = (state == S_CLEAR);
  assign DELAY_LINE_LOAD         = (state == S_LOAD);
  assign DELAY_LINE_MOVE         = (state == S_STEP);
  assign DELAY_LINE_DIRECTION    = dir_nxt;
  assign TAP_POS                 = tap;
  assign EARLY_CNT               = early_cnt;
  assign LATE_CNT                = late_cnt;
  assign TRAIN_BUSY              = busy;
  assign TRAIN_DONE              = (state == S_DONE);
  assign TRAIN_ERR               = (state == S_ERR);

endmodule

// File: tb/tb_iod_eye_flag_tracker.sv
// Bench for iod_eye_flag_tracker: iteration-position reference model checked every
// cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_iod_eye_flag_tracker;

  localparam int C    = 2;
  localparam int S    = 4;
  localparam int W    = 16;
  localparam int TH   = 4;
  localparam int MT   = 4;
  localparam int MS   = 5;
  localparam int ITER = C + S + W + 2;

  localparam int P_LOAD = 0, P_CLEAR = 1, P_SETTLE = 2, P_SAMPLE = 3, P_DECIDE = 4, P_STEP = 5;

  logic       clk = 0, rst = 1, start = 0, early = 0, late = 0, oor = 0;
  logic       clr, load, move, dir, busy, done, err;
  logic [7:0] tap, ecnt, lcnt;

  int n_chk = 0, n_err = 0;
  bit chk_en = 0;

  iod_eye_flag_tracker #(
    .SAMPLE_WINDOW(W), .CLEAR_CYCLES(C), .SETTLE_CYCLES(S),
    .THRESH(TH), .MAX_TAP(MT), .MAX_STEPS(MS)
  ) dut (
    .FAB_CLK(clk), .RX_SYNC_RST(rst), .TRAIN_START(start),
    .EYE_MONITOR_EARLY(early), .EYE_MONITOR_LATE(late),
    .DELAY_LINE_OUT_OF_RANGE(oor), .EYE_MONITOR_CLEAR_FLAGS(clr),
    .DELAY_LINE_LOAD(load), .DELAY_LINE_MOVE(move), .DELAY_LINE_DIRECTION(dir),
    .TAP_POS(tap), .EARLY_CNT(ecnt), .LATE_CNT(lcnt),
    .TRAIN_BUSY(busy), .TRAIN_DONE(done), .TRAIN_ERR(err)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model: training described by position since LOAD
  int m_busy = 0, m_pos = 0, m_term = 0, m_tap = 0, m_steps = 0;
  int m_ec = 0, m_lc = 0, m_dir = 0, m_ef = 0, m_lf = 0;

  function automatic int phase(input int p);
    int k;
    if (p == 0) return P_LOAD;
    k = (p - 1) % ITER;
    if (k < C) return P_CLEAR;
    if (k < C + S) return P_SETTLE;
    if (k < C + S + W) return P_SAMPLE;
    if (k == C + S + W) return P_DECIDE;
    return P_STEP;
  endfunction

  function automatic int m_dir_out();
    if (m_busy != 0 && phase(m_pos) == P_DECIDE && !(m_ec < TH && m_lc < TH))
      return (m_ec > m_lc) ? 1 : 0;
    return m_dir;
  endfunction

  always @(posedge clk) begin
    int d, ph, nterm;
    d = m_dir_out();
    if (rst) begin
      m_busy = 0; m_term = 0; m_tap = 0; m_steps = 0; m_ec = 0; m_lc = 0; m_dir = 0;
    end else if (m_busy == 0) begin
      if (start) begin
        m_busy = 1; m_pos = 0; m_term = 0; m_tap = 0; m_steps = 0;
      end
    end else begin
      ph = phase(m_pos);
      nterm = 0;
      if (ph == P_SAMPLE) begin
        if (m_ef != 0 && m_ec < 255) m_ec++;
        if (m_lf != 0 && m_lc < 255) m_lc++;
      end
      if (ph == P_DECIDE) begin
        if (m_ec < TH && m_lc < TH) nterm = 1;
        else if ((d == 1 && m_tap == MT) || (d == 0 && m_tap == 0) || m_steps == MS) nterm = 2;
      end
      if (ph == P_STEP) begin
        m_tap = (d == 1) ? m_tap + 1 : m_tap - 1;
        m_steps++;
      end
      if (oor) nterm = 2;
      m_dir = d;
      if (nterm != 0) begin
        m_busy = 0; m_term = nterm;
      end else begin
        m_pos++;
        if (phase(m_pos) == P_CLEAR && phase(m_pos - 1) != P_CLEAR) begin
          m_ec = 0; m_lc = 0;
        end
      end
    end
    m_ef = int'(early);
    m_lf = int'(late);
  end

  // ---------------- every-cycle comparison against the model
  always @(negedge clk) begin
    int ph;
    if (chk_en) begin
      ph = (m_busy != 0) ? phase(m_pos) : -1;
      cmp("load",  int'(load), int'(ph == P_LOAD));
      cmp("clear", int'(clr),  int'(ph == P_CLEAR));
      cmp("move",  int'(move), int'(ph == P_STEP));
      cmp("busy",  int'(busy), m_busy);
      cmp("done",  int'(done), int'(m_busy == 0 && m_term == 1));
      cmp("err",   int'(err),  int'(m_busy == 0 && m_term == 2));
      cmp("dir",   int'(dir),  m_dir_out());
      cmp("tap",   int'(tap),  m_tap);
      cmp("ecnt",  int'(ecnt), m_ec);
      cmp("lcnt",  int'(lcnt), m_lc);
    end
  end

  task automatic do_reset();
    rst = 1; start = 0; oor = 0;
    @(negedge clk); @(negedge clk);
    rst = 0;
  endtask

  // called at a negedge; returns at the negedge of cycle 1 (LOAD)
  task automatic do_start();
    start = 1;
    @(negedge clk);
    start = 0;
  endtask

  initial begin
    int ld, cf, cn, dn, mv, up, d24, ec_at, post, pulses, pe, pl;
    @(negedge clk);
    do_reset();
    chk_en = 1;
    cmp("reset_busy", int'(busy), 0);
    cmp("reset_tap", int'(tap), 0);

    // flags idle: zero-step done
    early = 0; late = 0;
    do_start();
    ld = -1; cf = -1; cn = 0; dn = -1; mv = 0;
    for (int c = 1; c <= 30; c++) begin
      if (load && ld < 0) ld = c;
      if (clr) begin if (cf < 0) cf = c; cn++; end
      if (done && dn < 0) dn = c;
      if (move) mv++;
      @(negedge clk);
    end
    cmp("idle_load_cycle", ld, 1);
    cmp("idle_clear_first", cf, 2);
    cmp("idle_clear_len", cn, 2);
    cmp("idle_done_cycle", dn, 25);
    cmp("idle_tap", int'(tap), 0);
    cmp("idle_moves", mv, 0);

    // early for three windows
    do_reset();
    early = 1;
    do_start();
    mv = 0; up = 0;
    for (int c = 1; c <= 200; c++) begin
      if (move) begin mv++; if (dir) up++; end
      early = (mv < 3);
      if (done || err) break;
      @(negedge clk);
    end
    early = 0;
    cmp("early3_moves", mv, 3);
    cmp("early3_up", up, 3);
    cmp("early3_tap", int'(tap), 3);
    cmp("early3_done", int'(done), 1);
    cmp("early3_ecnt", int'(ecnt), 0);

    // late constant: cannot remove delay at tap 0
    do_reset();
    late = 1;
    do_start();
    mv = 0; d24 = -1; dn = -1;
    for (int c = 1; c <= 60; c++) begin
      if (c == 24) d24 = int'(dir);
      if (move) mv++;
      if (err) begin dn = c; break; end
      @(negedge clk);
    end
    late = 0;
    cmp("late_dir_decide", d24, 0);
    cmp("late_err_cycle", dn, 25);
    cmp("late_lcnt", int'(lcnt), 16);
    cmp("late_err", int'(err), 1);
    cmp("late_busy", int'(busy), 0);
    cmp("late_moves", mv, 0);

    // out-of-range in the second SAMPLE window
    do_reset();
    early = 1;
    do_start();
    mv = 0; dn = -1; post = 0;
    for (int c = 1; c <= 70; c++) begin
      if (move) mv++;
      if (err && dn < 0) dn = c;
      if (c > 40 && (move || clr)) post++;
      early = (mv < 1);
      oor = (c == 40);
      @(negedge clk);
    end
    oor = 0; early = 0;
    cmp("oor_err_cycle", dn, 41);
    cmp("oor_no_pulses", post, 0);
    cmp("oor_tap", int'(tap), 1);
    cmp("oor_err", int'(err), 1);

    // alternating early/late hits the step limit
    do_reset();
    early = 1; late = 0;
    do_start();
    mv = 0;
    for (int c = 1; c <= 300; c++) begin
      if (move) mv++;
      early = (mv % 2 == 0);
      late  = (mv % 2 == 1);
      if (done || err) break;
      @(negedge clk);
    end
    early = 0; late = 0;
    cmp("steps_moves", mv, 5);
    cmp("steps_err", int'(err), 1);
    cmp("steps_tap", int'(tap), 1);

    // start while busy is ignored; reset mid-SAMPLE
    do_reset();
    early = 1;
    do_start();
    pulses = 0; ec_at = -1;
    for (int c = 1; c <= 30; c++) begin
      if (c == 6) begin
        cmp("busy_start_busy", int'(busy), 1);
        cmp("busy_start_noload", int'(load), 0);
      end
      if (c == 12) ec_at = int'(ecnt);
      if (c == 13)
        cmp("rst_outputs", int'({load, move, dir, clr, busy, done, err, tap, ecnt, lcnt}), 0);
      if (c > 13 && (load || move || clr)) pulses++;
      start = (c == 5);
      rst = (c == 12);
      @(negedge clk);
    end
    early = 0;
    cmp("mid_sample_ecnt", ec_at, 4);
    cmp("rst_no_pulses", pulses, 0);

    // randomized traffic checked by the model
    pe = 0; pl = 0;
    for (int c = 0; c < 3000; c++) begin
      if (c % 64 == 0) begin
        case ($urandom_range(0, 3))
          0: pe = 0; 1: pe = 5; 2: pe = 30; default: pe = 80;
        endcase
        case ($urandom_range(0, 3))
          0: pl = 0; 1: pl = 5; 2: pl = 30; default: pl = 80;
        endcase
      end
      early = ($urandom_range(0, 99) < pe);
      late  = ($urandom_range(0, 99) < pl);
      start = ($urandom_range(0, 15) == 0);
      oor   = ($urandom_range(0, 399) == 0);
      rst   = ($urandom_range(0, 599) == 0);
      @(negedge clk);
    end
    rst = 0; start = 0; oor = 0;
    @(negedge clk);
    chk_en = 0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
